fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register. It sits directly upstream of the decode stage and consumes StallF, StallD and FlushD from the hazard unit, plus the PCSrcE/PCTargetE redirect from execute. It owns the PC, drives a variable-latency instruction-memory request/response interface with one outstanding request, and presents InstrD/PCD/PCPlus4D/ValidD to decode. It also absorbs responses that arrive during a decode stall, and discards responses that a redirect has made stale.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, encoding driven on InstrD for bubbles (addi x0,x0,0)

Ports:
clk  in  1  clock, all state updates on the rising edge
reset  in  1  asynchronous, active-high
StallF  in  1  hold PC, issue no new request
StallD  in  1  hold the IF/ID outputs
FlushD  in  1  replace the IF/ID contents with a bubble
PCSrcE  in  1  taken branch/jump redirect from execute
PCTargetE  in  32  redirect target
imem_req  out  1  request valid
imem_addr  out  32  request address (word-aligned)
imem_gnt  in  1  memory accepts the request when imem_req & imem_gnt
imem_rvalid  in  1  response valid, at least 1 cycle after acceptance
imem_rdata  in  32  response instruction
InstrD  out  32  instruction to decode
PCD  out  32  PC of InstrD
PCPlus4D  out  32  PCD+4
ValidD  out  1  InstrD is a real instruction (0 = bubble)

Behaviour:
- Reset (async, active-high) sets: PCF=RESET_PC, state=IDLE, buffer empty, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0. imem_req=0 while reset is high.
- State machine, one outstanding request max:
  - IDLE = nothing outstanding.
  - WAIT = live request outstanding; its PC is held in pc_out.
  - WAIT_KILL = outstanding request made stale by a redirect.
- imem_req (combinational) = !reset & !PCSrcE & !StallF & !buf_valid & !(imem_rvalid & StallD) & (state==IDLE | imem_rvalid).
- imem_addr = PCF.
- On accept (imem_req & imem_gnt): pc_out<=PCF; PCF<=PCF+4 (32-bit wrap, 0xFFFF_FFFC+4=0); state->WAIT.
- On imem_rvalid in WAIT without a same-cycle accept: state->IDLE. On imem_rvalid in WAIT_KILL: data dropped, state->IDLE (or WAIT on a same-cycle accept).
- imem_rvalid in IDLE is a protocol error: ignored, with an assertion in simulation.
- Redirect (PCSrcE=1) has top priority over StallF/StallD:
  - PCF<=PCTargetE.
  - Buffer cleared.
  - Any same-cycle imem_rvalid is dropped.
  - WAIT->WAIT_KILL, IDLE stays IDLE.
  - No request is issued that cycle; fetch of the target starts the next cycle.
- IF/ID update, evaluated in priority order:
  1. FlushD: bubble. InstrD=NOP_INSTR, ValidD=0, PCD/PCPlus4D hold.
  2. StallD: all IF/ID outputs hold.
  3. buf_valid: load from buffer, buffer cleared.
  4. Live response (WAIT & imem_rvalid & !PCSrcE): load imem_rdata, pc_out, pc_out+4, ValidD=1.
  5. Otherwise: bubble.
- Skid buffer: one entry (instr, pc). Written when a live response arrives with StallD=1 and FlushD=0. FlushD or PCSrcE clears it.
  - Invariant: buf_valid and an outstanding request are never both true.
- StallF with StallD (load-use): no new request. A response already in flight lands in the buffer.
- Throughput: with gnt=1 and 1-cycle memory latency, one instruction per cycle. Redirect penalty is 2 bubbles plus memory latency.
- Reset asserted mid-request: everything returns to reset values. A later rvalid arrives in IDLE and is ignored.

Test Plan:
1. Reset release, gnt=1, 1-cycle latency, rdata=addr|1 -> imem_addr 0,4,8,... on consecutive cycles; InstrD=1,5,9 with PCD=0,4,8; ValidD=1 from the 3rd cycle after release.
2. StallF=StallD=1 for 2 cycles while the request for PC 0x10 is outstanding -> response captured in buffer; IF/ID holds; no imem_req. On release, InstrD=resp(0x10), PCD=0x10, no instruction lost or duplicated.
3. PCSrcE=1, PCTargetE=0x100 while the request for 0x20 is outstanding with 3-cycle latency -> 0x20 response dropped; next imem_addr=0x100; first ValidD=1 has PCD=0x100.
4. PCSrcE=1 and StallF=1 in the same cycle -> PCF=PCTargetE next cycle; FlushD bubble (ValidD=0, InstrD=0x13).
5. gnt held 0 for 4 cycles -> imem_req stays 1 with a stable imem_addr; ValidD=0 bubbles; PCF not incremented until accept.
6. Reset asserted mid-WAIT, then rvalid -> outputs at reset values; stray rvalid ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory request/response bus between fetch and imem
//
// Purpose: groups the single-outstanding imem handshake into one port.
// Signals:
//   imem_req    master->slave  request valid
//   imem_addr   master->slave  request address (word-aligned)
//   imem_gnt    slave->master  request accepted when imem_req & imem_gnt
//   imem_rvalid slave->master  response valid, >=1 cycle after acceptance
//   imem_rdata  slave->master  response instruction
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register and one-entry skid buffer
//
// Purpose: owns the PC, issues at most one outstanding imem request, absorbs a
// response that lands during a decode stall, and drops responses made stale by
// an execute-stage redirect.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   StallF, StallD      hazard-unit stalls for fetch and the IF/ID register
//   FlushD              replace IF/ID contents with a bubble
//   PCSrcE, PCTargetE   redirect request and target from execute
//   imem                instruction-memory bus (master side)
//   InstrD, PCD,        instruction, its PC and PC+4 presented to decode
//   PCPlus4D, ValidD    ValidD=0 marks a bubble
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 StallF,
  input  logic                 StallD,
  input  logic                 FlushD,
  input  logic                 PCSrcE,
  input  logic [31:0]          PCTargetE,
  fetch_stage_if.master        imem,
  output logic [31:0]          InstrD,
  output logic [31:0]          PCD,
  output logic [31:0]          PCPlus4D,
  output logic                 ValidD
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    WAIT_KILL
  } fetchState_t;

  fetchState_t state, stateNext;

  logic [31:0] pcF;
  logic [31:0] pcOut;
  logic [31:0] bufInstr;
  logic [31:0] bufPc;
  logic        bufValid;
  logic        imemReq;
  logic        accept;
  logic        liveResp;

  // Request/next-state logic. A new request may overlap the cycle in which the
  // previous response returns, which is what gives one instruction per cycle.
  always_comb begin
    imemReq   = 1'b0;
    accept    = 1'b0;
    liveResp  = 1'b0;
    stateNext = state;

    imemReq = !reset && !PCSrcE && !StallF && !bufValid
              && !(imem.imem_rvalid && StallD)
              && ((state == IDLE) || imem.imem_rvalid);
    accept   = imemReq && imem.imem_gnt;
    liveResp = (state == WAIT) && imem.imem_rvalid && !PCSrcE;

    if (PCSrcE) begin
      // A response returning in the redirect cycle retires the outstanding
      // request; otherwise the request still in flight becomes stale.
      if (imem.imem_rvalid) begin
        stateNext = IDLE;
      end else if (state == WAIT) begin
        stateNext = WAIT_KILL;
      end
    end else if (accept) begin
      stateNext = WAIT;
    end else if (imem.imem_rvalid && (state != IDLE)) begin
      stateNext = IDLE;
    end
  end

  assign imem.imem_req  = imemReq;
  assign imem.imem_addr = pcF;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // PC and the address of the outstanding request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcF   <= RESET_PC;
      pcOut <= RESET_PC;
    end else if (PCSrcE) begin
      pcF <= PCTargetE;
    end else if (accept) begin
      pcOut <= pcF;
      pcF   <= pcF + 32'd4;
    end
  end

  // Skid buffer: catches a live response while decode is stalled. Because the
  // request logic is blocked while it is full, it never coexists with an
  // outstanding request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bufValid <= 1'b0;
      bufInstr <= NOP_INSTR;
      bufPc    <= 32'd0;
    end else if (PCSrcE || FlushD) begin
      bufValid <= 1'b0;
    end else if (liveResp && StallD) begin
      bufValid <= 1'b1;
      bufInstr <= imem.imem_rdata;
      bufPc    <= pcOut;
    end else if (bufValid && !StallD) begin
      bufValid <= 1'b0;
    end
  end

  // IF/ID register; a bubble keeps the previous PCD/PCPlus4D.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end else if (StallD) begin
      InstrD <= InstrD;
    end else if (bufValid) begin
      InstrD   <= bufInstr;
      PCD      <= bufPc;
      PCPlus4D <= bufPc + 32'd4;
      ValidD   <= 1'b1;
    end else if (liveResp) begin
      InstrD   <= imem.imem_rdata;
      PCD      <= pcOut;
      PCPlus4D <= pcOut + 32'd4;
      ValidD   <= 1'b1;
    end else begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end
  end

  // A response with nothing outstanding is a memory protocol error.
  rvalidInIdle : assert property (@(posedge clk) disable iff (reset)
                                  !(imem.imem_rvalid && (state == IDLE)))
    else $error("imem_rvalid received with no outstanding request");

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;
  logic        clk;
  logic        reset;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk       (clk),
    .reset     (reset),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .imem      (bus),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
  );

  int compCnt = 0;
  int errCnt  = 0;

  // Memory responder state: one outstanding request, rdata = addr | 1.
  int          lat     = 1;
  int          memCnt  = 0;
  logic [31:0] memAddr = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compCnt++;
    assert (obs === exp)
    else begin
      errCnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: capture acceptance just before the edge, then drive the memory
  // response for the next cycle and let it settle before checks.
  task automatic tick();
    logic        acc;
    logic [31:0] accAddr;
    #1;
    acc     = bus.imem_req & bus.imem_gnt;
    accAddr = bus.imem_addr;
    @(posedge clk);
    #1;
    bus.imem_rvalid = 1'b0;
    if (acc) begin
      memAddr = accAddr;
      memCnt  = lat;
    end
    if (memCnt > 0) begin
      memCnt--;
      if (memCnt == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = memAddr | 32'd1;
      end
    end
    #1;
  endtask

  task automatic chkIfId(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                         input logic valid);
    chk({tag, ".InstrD"}, InstrD, instr);
    chk({tag, ".PCD"}, PCD, pc);
    chk({tag, ".PCPlus4D"}, PCPlus4D, pc + 32'd4);
    chk({tag, ".ValidD"}, {31'd0, ValidD}, {31'd0, valid});
  endtask

  initial begin
    reset = 1'b1;
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    PCTargetE = 32'd0;
    bus.imem_gnt = 1'b1; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'd0;
    tick(); tick();

    // Reset state
    chk("rst.InstrD", InstrD, 32'h13);
    chk("rst.PCD", PCD, 32'd0);
    chk("rst.PCPlus4D", PCPlus4D, 32'd0);
    chk("rst.ValidD", {31'd0, ValidD}, 32'd0);
    chk("rst.req", {31'd0, bus.imem_req}, 32'd0);

    // 1: streaming, 1-cycle latency
    reset = 1'b0; #1;
    chk("t1.req0", {31'd0, bus.imem_req}, 32'd1);
    chk("t1.addr0", bus.imem_addr, 32'h0);
    tick();
    chk("t1.addr1", bus.imem_addr, 32'h4);
    chk("t1.valid1", {31'd0, ValidD}, 32'd0);
    tick();
    chk("t1.addr2", bus.imem_addr, 32'h8);
    chkIfId("t1.c2", 32'h1, 32'h0, 1'b1);
    tick();
    chkIfId("t1.c3", 32'h5, 32'h4, 1'b1);
    tick();
    chkIfId("t1.c4", 32'h9, 32'h8, 1'b1);
    chk("t1.addr4", bus.imem_addr, 32'h10);
    tick();
    chkIfId("t1.c5", 32'hD, 32'hC, 1'b1);

    // 2: load-use stall while 0x10 response is in flight
    StallF = 1'b1; StallD = 1'b1; #1;
    chk("t2.reqStall", {31'd0, bus.imem_req}, 32'd0);
    tick();
    chkIfId("t2.hold1", 32'hD, 32'hC, 1'b1);
    chk("t2.req1", {31'd0, bus.imem_req}, 32'd0);
    tick();
    chkIfId("t2.hold2", 32'hD, 32'hC, 1'b1);
    StallF = 1'b0; StallD = 1'b0; #1;
    chk("t2.reqBuf", {31'd0, bus.imem_req}, 32'd0);
    tick();
    chkIfId("t2.fromBuf", 32'h11, 32'h10, 1'b1);
    chk("t2.req", {31'd0, bus.imem_req}, 32'd1);
    chk("t2.addr", bus.imem_addr, 32'h14);
    tick();
    chk("t2.bubble", {31'd0, ValidD}, 32'd0);
    tick();
    chkIfId("t2.next", 32'h15, 32'h14, 1'b1);

    // 3: redirect while 0x20 is outstanding, 3-cycle latency
    lat = 3;
    tick(); tick(); tick();
    chk("t3.addr20", bus.imem_addr, 32'h20);
    chk("t3.req20", {31'd0, bus.imem_req}, 32'd1);
    tick();
    chkIfId("t3.c1C", 32'h1D, 32'h1C, 1'b1);
    PCSrcE = 1'b1; PCTargetE = 32'h100; #1;
    chk("t3.reqRedir", {31'd0, bus.imem_req}, 32'd0);
    tick();
    PCSrcE = 1'b0;
    tick();
    chk("t3.staleRvalid", {31'd0, bus.imem_rvalid}, 32'd1);
    chk("t3.addr100", bus.imem_addr, 32'h100);
    chk("t3.req100", {31'd0, bus.imem_req}, 32'd1);
    tick();
    chk("t3.dropped", {31'd0, ValidD}, 32'd0);
    tick(); tick();
    lat = 1;
    tick();
    chkIfId("t3.first", 32'h101, 32'h100, 1'b1);

    // 4: redirect with StallF and FlushD in the same cycle
    PCSrcE = 1'b1; StallF = 1'b1; FlushD = 1'b1; PCTargetE = 32'h200;
    tick();
    PCSrcE = 1'b0; StallF = 1'b0; FlushD = 1'b0; #1;
    chk("t4.InstrD", InstrD, 32'h13);
    chk("t4.ValidD", {31'd0, ValidD}, 32'd0);
    chk("t4.PCD", PCD, 32'h100);
    chk("t4.addr", bus.imem_addr, 32'h200);

    // 5: grant withheld for 4 cycles
    bus.imem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5.req", {31'd0, bus.imem_req}, 32'd1);
      chk("t5.addr", bus.imem_addr, 32'h200);
      chk("t5.valid", {31'd0, ValidD}, 32'd0);
    end
    bus.imem_gnt = 1'b1;
    tick();
    chk("t5.addrNext", bus.imem_addr, 32'h204);
    lat = 3;
    tick();
    chkIfId("t5.instr", 32'h201, 32'h200, 1'b1);

    // 6: reset mid-WAIT, stale response arrives while reset is held
    reset = 1'b1; #1;
    chk("t6.InstrD", InstrD, 32'h13);
    chk("t6.PCD", PCD, 32'd0);
    chk("t6.PCPlus4D", PCPlus4D, 32'd0);
    chk("t6.ValidD", {31'd0, ValidD}, 32'd0);
    chk("t6.req", {31'd0, bus.imem_req}, 32'd0);
    tick(); tick();
    chk("t6.strayRvalid", {31'd0, bus.imem_rvalid}, 32'd1);
    tick();
    chk("t6.ignored", {31'd0, ValidD}, 32'd0);
    lat = 1;
    reset = 1'b0; #1;
    chk("t6.restartReq", {31'd0, bus.imem_req}, 32'd1);
    chk("t6.restartAddr", bus.imem_addr, 32'h0);
    tick(); tick();
    chkIfId("t6.first", 32'h1, 32'h0, 1'b1);

    // 7: PC wrap at the top of the address space
    PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    tick();
    PCSrcE = 1'b0; FlushD = 1'b0; #1;
    chk("t7.addrTop", bus.imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("t7.addrWrap", bus.imem_addr, 32'h0);
    tick();
    chkIfId("t7.instr", 32'hFFFF_FFFD, 32'hFFFF_FFFC, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, errCnt);
    $finish;
  end
endmodule
